// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, runtime oversampling, 3-sample majority
// per bit, optional parity, single-cycle result pulses after the stop decision.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_uart,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_parity_enable,
  input  logic                      i_parity_type,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_data_valid,
  output logic                      o_parity_error,
  output logic                      o_stop_error,
  output logic                      o_busy_flag
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0]            BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] P_MIN    = PRESCALE_WIDTH'(4);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state, state_next;
  logic                      sync1, rx_s;
  logic [PRESCALE_WIDTH-1:0] p_lat, p_in, half, edge_cnt;
  logic [BCW-1:0]            bit_cnt;
  logic                      samp0, samp1, vote;
  logic                      decide, bit_end;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_en, par_type, par_err;

  // Prescale is clamped to 4 and forced even so the three samples sit symmetrically around mid-bit.
  assign p_in    = (i_prescale < P_MIN) ? P_MIN : (i_prescale & ~ONE);
  assign half    = p_lat >> 1;
  assign decide  = (edge_cnt == half + ONE);
  assign bit_end = (edge_cnt == p_lat - ONE);
  assign vote    = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_uart;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!rx_s) state_next = START;
      START: begin
        if (decide && vote) state_next = IDLE;
        else if (bit_end)   state_next = DATA;
      end
      DATA:    if (bit_end && bit_cnt == BIT_LAST) state_next = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (decide) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_lat    <= P_MIN;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_type <= 1'b0;
      par_err  <= 1'b0;
    end else if (state == IDLE) begin
      if (!rx_s) begin
        p_lat    <= p_in;
        edge_cnt <= '0;
        bit_cnt  <= '0;
        par_en   <= i_parity_enable;
        par_type <= i_parity_type;
        par_err  <= 1'b0;
      end
    end else begin
      edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
      if (edge_cnt == half - ONE) samp0 <= rx_s;
      if (edge_cnt == half)       samp1 <= rx_s;
      if (state == DATA && decide)  shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
      if (state == PARITY && decide) par_err <= vote ^ (^shreg) ^ par_type;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
    end else begin
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
      if (state == STOP && decide) begin
        o_data         <= shreg;
        o_data_valid   <= vote & ~par_err;
        o_parity_error <= par_en & par_err;
        o_stop_error   <= ~vote;
      end
    end
  end

  // Busy drops already in the stop decision cycle so a back-to-back start bit is not missed.
  always_comb begin
    o_busy_flag = (state != IDLE) && !(state == STOP && decide);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised frames for uart_rx, checked against a frame-level reference model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       pen = 1'b0;
  logic       ptype = 1'b0;
  logic [7:0] data;
  logic       dv, perr, serr, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart(uart), .i_prescale(prescale),
    .i_parity_enable(pen), .i_parity_type(ptype), .o_data(data),
    .o_data_valid(dv), .o_parity_error(perr), .o_stop_error(serr), .o_busy_flag(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       v;
    logic       pe;
    logic       se;
  } ev_t;

  ev_t  evq[$];
  int   busy_rise = -1;
  int   busy_fall = -1;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dv || perr || serr) evq.push_back('{t: cyc, d: data, v: dv, pe: perr, se: serr});
      if (busy && !busy_prev) busy_rise = cyc;
      if (!busy && busy_prev) busy_fall = cyc;
    end
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic int p_eff(input int p);
    int q;
    q = (p < 4) ? 4 : p;
    return q - (q % 2);
  endfunction

  // Cycles from the first edge that samples the start bit to the result pulse.
  function automatic int latency(input int p, input logic par_on);
    int pe;
    pe = p_eff(p);
    return 2 + (9 + int'(par_on)) * pe + pe / 2 + 2;
  endfunction

  // Must be called at a negedge; returns at a negedge right after the stop bit.
  task automatic send_frame(input logic [7:0] d, input int bit_len, input logic with_par,
                            input logic pbit, input logic stop_bit, output int c0);
    uart = 1'b0;
    c0 = cyc + 1;
    repeat (bit_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart = d[i];
      repeat (bit_len) @(negedge clk);
    end
    if (with_par) begin
      uart = pbit;
      repeat (bit_len) @(negedge clk);
    end
    uart = stop_bit;
    repeat (bit_len) @(negedge clk);
    uart = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int c0, input int p, input logic par_on,
                              input logic typ, input logic [7:0] d, input logic pbit,
                              input logic stop_bit);
    logic exp_pe, exp_se;
    ev_t  e;
    exp_pe = par_on && (pbit != ((^d) ^ typ));
    exp_se = !stop_bit;
    for (int i = 0; i < 400 && evq.size() == 0; i++) @(negedge clk);
    check({tag, "_present"}, 32'(evq.size() != 0), 32'd1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      check({tag, "_time"}, 32'(e.t - c0), 32'(latency(p, par_on)));
      check({tag, "_data"}, 32'(e.d), 32'(d));
      check({tag, "_valid"}, 32'(e.v), 32'(!exp_pe && !exp_se));
      check({tag, "_perr"}, 32'(e.pe), 32'(exp_pe));
      check({tag, "_serr"}, 32'(e.se), 32'(exp_se));
    end
  endtask

  int         c0, c1, pe, praw;
  logic [7:0] d;
  logic       pb, sb, pon, pty;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'd0);
    check("rst_flags", {29'd0, dv, perr, serr}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // P=8, even parity, 0xA5
    prescale = 6'd8; pen = 1'b1; ptype = 1'b0;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, c0);
    expect_frame("a5", c0, 8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    check("a5_lat88", 32'(latency(8, 1'b1)), 32'd88);
    check("a5_busy_rise", 32'(busy_rise - c0), 32'd2);
    check("a5_busy_fall", 32'(busy_fall - c0), 32'(latency(8, 1'b1) - 1));
    repeat (20) @(negedge clk);
    check("a5_quiet", 32'(evq.size()), 32'd0);

    // P=16, no parity, back-to-back frames
    prescale = 6'd16; pen = 1'b0;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, c0);
    send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, c1);
    check("b2b_gap", 32'(c1 - c0), 32'd160);
    expect_frame("b2b_0", c0, 16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    expect_frame("b2b_1", c1, 16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    repeat (40) @(negedge clk);

    // P=8, odd parity, wrong parity bit
    prescale = 6'd8; pen = 1'b1; ptype = 1'b1;
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1, c0);
    expect_frame("par_bad", c0, 8, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
    repeat (30) @(negedge clk);

    // Stop bit forced low, then a good frame
    pen = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, c0);
    expect_frame("stop_bad", c0, 8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("stop_quiet", 32'(evq.size()), 32'd0);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, c0);
    expect_frame("after_stop", c0, 8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1);
    repeat (30) @(negedge clk);

    // 2-cycle glitch on idle line
    uart = 1'b0;
    c0 = cyc + 1;
    repeat (2) @(negedge clk);
    uart = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_events", 32'(evq.size()), 32'd0);
    check("glitch_data", 32'(data), 32'h12);
    check("glitch_rise", 32'(busy_rise - c0), 32'd2);
    check("glitch_fall", 32'(busy_fall - c0), 32'(2 + 8 / 2 + 2));

    // Reset in the middle of the data bits of 0x7E
    d = 8'h7E;
    uart = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart = d[i];
      repeat (8) @(negedge clk);
    end
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_flags", {28'd0, dv, perr, serr, busy}, 32'd0);
    uart = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_quiet", 32'(evq.size()), 32'd0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, c0);
    expect_frame("after_rst", c0, 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
    repeat (30) @(negedge clk);

    // Randomised frames: prescale incl. odd and sub-4 values, parity and stop corruption
    for (int n = 0; n < 24; n++) begin
      praw = $urandom_range(0, 63);
      pe   = p_eff(praw);
      d    = 8'($urandom);
      pon  = 1'($urandom);
      pty  = 1'($urandom);
      pb   = (^d) ^ pty;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sb   = ($urandom_range(0, 7) != 0);
      prescale = 6'(praw); pen = pon; ptype = pty;
      send_frame(d, pe, pon, pb, sb, c0);
      expect_frame($sformatf("rnd%0d", n), c0, praw, pon, pty, d, pb, sb);
      repeat (3 * pe + 10) @(negedge clk);
      check($sformatf("rnd%0d_quiet", n), 32'(evq.size()), 32'd0);
      evq.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that consumes the line produced by the UART transmitter (o_uart) and rebuilds parallel words. The frame format matches the transmitter: start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit 1. The line is oversampled by a runtime prescale ratio, and each bit is decided by a 3-sample majority vote. Each word is presented with a one-cycle valid pulse, plus parity and framing error flags.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of i_prescale

Ports:
i_clk  input  1  single clock; all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_uart  input  1  serial line; asynchronous to i_clk; idle high
i_prescale  input  PRESCALE_WIDTH  clocks per bit (oversample ratio); legal range 4..63
i_parity_enable  input  1  1 = parity bit present in frame
i_parity_type  input  1  0 = even, 1 = odd (same encoding as the transmitter)
o_data  output  DATA_WIDTH  last received word
o_data_valid  output  1  one-cycle pulse: o_data updated and frame is good
o_parity_error  output  1  one-cycle pulse: parity mismatch
o_stop_error  output  1  one-cycle pulse: stop bit sampled as 0
o_busy_flag  output  1  high while a frame is being received

Behaviour:
- Reset (async, i_rst_n=0):
  - o_data=0; o_data_valid, o_parity_error, o_stop_error, o_busy_flag = 0.
  - FSM enters IDLE; synchronizer flops = 1.
- Input path: i_uart passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- Prescale latching:
  - i_prescale is latched as P at start detection and held for the whole frame.
  - Values below 4 are treated as 4.
  - P is used as an even number: bit 0 is ignored.
- Bit timing:
  - edge_cnt runs 0..P-1 within each bit, then wraps, and bit_cnt increments.
  - Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, decided in the cycle edge_cnt = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: wait for rx_s = 0. On detection, latch P, set edge_cnt=0, go to START, set o_busy_flag=1.
  - START: if the start decision is 1 (glitch), return to IDLE, clear busy, assert no flags. Otherwise continue to DATA at the bit boundary.
  - DATA: shift decided bits in LSB first. After DATA_WIDTH bits, go to PARITY if i_parity_enable=1, else go to STOP.
  - PARITY: the expected bit is XOR of the data bits, XORed with i_parity_type. A mismatch is recorded.
  - STOP: at the stop decision cycle, the FSM returns to IDLE immediately, without waiting for the end of the stop bit. o_busy_flag drops in that same cycle, so a back-to-back start bit is caught.
- Result, registered and valid in the cycle after the stop decision (all three flags are single-cycle pulses):
  - o_data is loaded with the received word on every completed frame, including errored frames.
  - o_data_valid = stop ok AND parity ok.
  - o_parity_error = parity enabled AND mismatch.
  - o_stop_error = stop decision is 0.
  - Both error flags may pulse together. o_data_valid is never high together with an error flag.
- Latency, measured from the first clock edge where i_uart is sampled low to the o_data_valid cycle: 2 + (1+DATA_WIDTH+par)*P + P/2 + 2, where par = 1 if parity is enabled, else 0.
  - P=8, DATA_WIDTH=8, parity on: 88 cycles.
  - P=8, DATA_WIDTH=8, parity off: 80 cycles.
- i_parity_enable and i_parity_type are sampled at start detection and held for the frame.
- Line stuck low (break): the frame ends with o_stop_error. The FSM returns to IDLE and re-triggers immediately on the still-low line. It produces a stop error every frame length until the line goes high. No hang.
- Reset asserted mid-frame: all state clears at once, with no partial output. After release, the FSM waits in IDLE for a fresh falling edge. A line already low at release is treated as a start.

Test Plan:
- P=8, parity on, even, transmit 0xA5 (parity bit 0) -> o_data=0xA5, o_data_valid pulses once at cycle 88, no error flags, o_busy_flag high cycles 2..86.
- P=16, parity off, two back-to-back frames 0x3C then 0xFF with a single stop bit between -> two valid pulses 160 cycles apart, o_data=0x3C then 0xFF.
- P=8, parity on, odd, send 0x01 with a wrong parity bit of 1 -> o_data=0x01, o_parity_error pulses once, o_data_valid stays 0.
- P=8, parity off, 0x55 with the stop bit forced to 0 -> o_stop_error pulses, o_data=0x55, o_data_valid=0, the next good frame 0x12 is received correctly.
- 2-cycle low glitch on an idle line with P=8 -> FSM returns to IDLE, no flags, o_busy_flag high only during the glitch window, o_data unchanged.
- Assert i_rst_n=0 in the middle of the DATA state of frame 0x7E -> all outputs 0 immediately; after release, a fresh frame 0x81 is received with valid and no errors.
